// File: rtl/lsu_mem_access.sv
// Load/store access unit: steers core loads/stores onto an NB-byte data bus,
// splitting accesses that cross a bus word into two beats when allowed.

module lsu_mem_lane #(
  parameter int NB    = 4,
  parameter int LANE  = 0,
  parameter int OFF_W = $clog2(NB)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                beat1,
  input  logic [OFF_W-1:0]    off,
  input  logic [3:0]          size,
  input  logic                cap,
  input  logic [NB-1:0][7:0]  wbytes,
  input  logic [NB-1:0][7:0]  rbytes,
  output logic                strb,
  output logic [7:0]          wbyte,
  output logic [7:0]          rbyte
);
  // k: request byte carried on this bus lane; j: bus lane feeding result byte LANE
  int  k, j;
  logic take;

  always_comb begin
    k     = LANE + (beat1 ? NB : 0) - int'(off);
    j     = LANE + int'(off) - (beat1 ? NB : 0);
    strb  = (k >= 0) && (k < int'(size));
    wbyte = strb ? wbytes[k[OFF_W-1:0]] : 8'h00;
    take  = cap && (j >= 0) && (j < NB) && (LANE < int'(size));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rbyte <= 8'h00;
    else if (take) rbyte <= rbytes[j[OFF_W-1:0]];
  end
endmodule

module lsu_mem_access #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
  } req_t;

  state_t state, state_nx;
  req_t   req_q;
  logic   err_q;

  // request decode, evaluated on the incoming request in IDLE
  logic [3:0] in_size;
  logic [2:0] in_mask;
  logic       in_illegal, in_misal;

  always_comb begin
    in_size    = 4'd1 << req_funct3[1:0];
    in_mask    = 3'(in_size - 4'd1);
    in_illegal = (req_funct3 == 3'b111) || (req_we && req_funct3[2]) ||
                 ((XLEN == 32) && ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110)));
    in_misal   = !ALLOW_MISALIGNED && (|(req_addr[2:0] & in_mask));
  end

  logic [3:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic              split_q, beat1, cap;
  logic [ADDR_W-1:0] base;

  assign size_q  = 4'd1 << req_q.funct3[1:0];
  assign off_q   = req_q.addr[OFF_W-1:0];
  assign split_q = (5'(off_q) + 5'(size_q)) > 5'(NB);
  assign base    = {req_q.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign beat1   = (state == B1_REQ) || (state == B1_WAIT);
  assign cap     = ((state == B0_WAIT) || (state == B1_WAIT)) && mem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        req_q <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
        err_q <= in_illegal || in_misal;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (in_illegal || in_misal) ? RESP : B0_REQ;
      B0_REQ:  if (mem_ready) state_nx = req_q.we ? (split_q ? B1_REQ : RESP) : B0_WAIT;
      B0_WAIT: if (mem_rvalid) state_nx = split_q ? B1_REQ : RESP;
      B1_REQ:  if (mem_ready) state_nx = req_q.we ? RESP : B1_WAIT;
      B1_WAIT: if (mem_rvalid) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic [NB-1:0]      strb;
  logic [NB-1:0][7:0] wbytes_s, rbuf, ext;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    lsu_mem_lane #(.NB(NB), .LANE(i)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .beat1  (beat1),
      .off    (off_q),
      .size   (size_q),
      .cap    (cap),
      .wbytes (req_q.wdata),
      .rbytes (mem_rdata),
      .strb   (strb[i]),
      .wbyte  (wbytes_s[i]),
      .rbyte  (rbuf[i])
    );
  end

  // unsigned variants carry funct3[2]; D always fills every byte so never extends
  logic sign;
  always_comb begin
    sign = rbuf[OFF_W'(size_q - 4'd1)][7] & ~req_q.funct3[2];
    ext  = '0;
    for (int k = 0; k < NB; k++)
      ext[k] = (k < int'(size_q)) ? rbuf[k] : {8{sign}};
  end

  assign req_ready = (state == IDLE);
  assign mem_valid = (state == B0_REQ) || (state == B1_REQ);
  assign mem_we    = mem_valid && req_q.we;
  assign mem_addr  = mem_valid ? (beat1 ? base + ADDR_W'(NB) : base) : '0;
  assign mem_wstrb = mem_valid ? strb : '0;
  assign mem_wdata = mem_we ? wbytes_s : '0;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !req_q.we) ? ext : '0;
endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: three instances cover 32-bit split-capable,
// 32-bit strict-alignment and 64-bit configurations.
module tb_lsu_mem_access;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // instance a: XLEN=32, misaligned split allowed
  logic a_req_valid, a_req_ready, a_req_we, a_mem_valid, a_mem_ready, a_mem_we;
  logic a_mem_rvalid, a_rsp_valid, a_rsp_err;
  logic [2:0] a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata, a_mem_addr, a_mem_wdata, a_mem_rdata, a_rsp_rdata;
  logic [3:0] a_mem_wstrb;
  // instance b: XLEN=32, strict alignment
  logic b_req_valid, b_req_ready, b_req_we, b_mem_valid, b_mem_ready, b_mem_we;
  logic b_mem_rvalid, b_rsp_valid, b_rsp_err;
  logic [2:0] b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata, b_mem_addr, b_mem_wdata, b_mem_rdata, b_rsp_rdata;
  logic [3:0] b_mem_wstrb;
  // instance c: XLEN=64
  logic c_req_valid, c_req_ready, c_req_we, c_mem_valid, c_mem_ready, c_mem_we;
  logic c_mem_rvalid, c_rsp_valid, c_rsp_err;
  logic [2:0] c_req_funct3;
  logic [31:0] c_req_addr, c_mem_addr;
  logic [63:0] c_req_wdata, c_mem_wdata, c_mem_rdata, c_rsp_rdata;
  logic [7:0] c_mem_wstrb;

  lsu_mem_access #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wstrb(a_mem_wstrb), .mem_wdata(a_mem_wdata), .mem_rvalid(a_mem_rvalid),
    .mem_rdata(a_mem_rdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

  lsu_mem_access #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata), .mem_rvalid(b_mem_rvalid),
    .mem_rdata(b_mem_rdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

  lsu_mem_access #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_we(c_req_we), .req_funct3(c_req_funct3), .req_addr(c_req_addr), .req_wdata(c_req_wdata),
    .mem_valid(c_mem_valid), .mem_ready(c_mem_ready), .mem_we(c_mem_we), .mem_addr(c_mem_addr),
    .mem_wstrb(c_mem_wstrb), .mem_wdata(c_mem_wdata), .mem_rvalid(c_mem_rvalid),
    .mem_rdata(c_mem_rdata), .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // single-beat load on instance a with a zero-wait bus
  task automatic a_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] word, input logic [31:0] exp);
    chk({tag, "_ready"}, 64'(a_req_ready), 64'h1);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_funct3 = f3; a_req_addr = addr;
    tick();
    a_req_valid = 1'b0;
    chk({tag, "_mvalid"}, 64'(a_mem_valid), 64'h1);
    chk({tag, "_maddr"}, 64'(a_mem_addr), 64'(addr & 32'hFFFF_FFFC));
    chk({tag, "_mwe"}, 64'(a_mem_we), 64'h0);
    a_mem_ready = 1'b1;
    tick();
    a_mem_ready = 1'b0;
    chk({tag, "_rsp_c2"}, 64'(a_rsp_valid), 64'h0);
    a_mem_rvalid = 1'b1; a_mem_rdata = word;
    tick();
    a_mem_rvalid = 1'b0;
    chk({tag, "_rsp_c3"}, 64'(a_rsp_valid), 64'h1);
    chk({tag, "_rdata"}, 64'(a_rsp_rdata), 64'(exp));
    chk({tag, "_err"}, 64'(a_rsp_err), 64'h0);
    tick();
    chk({tag, "_rsp_done"}, 64'(a_rsp_valid), 64'h0);
  endtask

  initial begin
    rst_n = 1'b1;
    {a_req_valid, a_req_we, a_mem_ready, a_mem_rvalid} = '0;
    {b_req_valid, b_req_we, b_mem_ready, b_mem_rvalid} = '0;
    {c_req_valid, c_req_we, c_mem_ready, c_mem_rvalid} = '0;
    a_req_funct3 = '0; a_req_addr = '0; a_req_wdata = '0; a_mem_rdata = '0;
    b_req_funct3 = '0; b_req_addr = '0; b_req_wdata = '0; b_mem_rdata = '0;
    c_req_funct3 = '0; c_req_addr = '0; c_req_wdata = '0; c_mem_rdata = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mvalid", 64'(a_mem_valid), 64'h0);
    chk("rst_maddr", 64'(a_mem_addr), 64'h0);
    chk("rst_wstrb", 64'(a_mem_wstrb), 64'h0);
    chk("rst_wdata", 64'(a_mem_wdata), 64'h0);
    chk("rst_rsp", 64'(a_rsp_valid), 64'h0);
    chk("rst_rdata", 64'(c_rsp_rdata), 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // aligned and sub-word loads
    a_load("lw", 3'b010, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    a_load("lb", 3'b000, 32'h103, 32'h80FF_FFFF, 32'hFFFF_FF80);
    a_load("lbu", 3'b100, 32'h103, 32'h80FF_FFFF, 32'h0000_0080);
    a_load("lhu", 3'b101, 32'h102, 32'h80FF_1234, 32'h0000_80FF);
    a_load("lh", 3'b001, 32'h100, 32'h0000_8001, 32'hFFFF_8001);

    // split store
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_funct3 = 3'b010;
    a_req_addr = 32'h102; a_req_wdata = 32'h1122_3344;
    tick();
    a_req_valid = 1'b0;
    chk("sw_b0_addr", 64'(a_mem_addr), 64'h100);
    chk("sw_b0_strb", 64'(a_mem_wstrb), 64'hC);
    chk("sw_b0_data", 64'(a_mem_wdata), 64'h3344_0000);
    chk("sw_b0_we", 64'(a_mem_we), 64'h1);
    a_mem_ready = 1'b1;
    tick();
    chk("sw_b1_valid", 64'(a_mem_valid), 64'h1);
    chk("sw_b1_addr", 64'(a_mem_addr), 64'h104);
    chk("sw_b1_strb", 64'(a_mem_wstrb), 64'h3);
    chk("sw_b1_data", 64'(a_mem_wdata), 64'h0000_1122);
    chk("sw_b1_rsp", 64'(a_rsp_valid), 64'h0);
    tick();
    a_mem_ready = 1'b0;
    chk("sw_rsp", 64'(a_rsp_valid), 64'h1);
    chk("sw_rdata", 64'(a_rsp_rdata), 64'h0);
    tick();
    chk("sw_rsp_once", 64'(a_rsp_valid), 64'h0);

    // split load with rvalid three cycles after each handshake
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_funct3 = 3'b010; a_req_addr = 32'h101;
    tick();
    a_req_valid = 1'b0;
    chk("slw_b0_addr", 64'(a_mem_addr), 64'h100);
    chk("slw_b0_strb", 64'(a_mem_wstrb), 64'hE);
    a_mem_ready = 1'b1;
    tick();
    a_mem_ready = 1'b0;
    tick(); tick();
    chk("slw_wait", 64'(a_mem_valid), 64'h0);
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'hAABB_CCDD;
    tick();
    a_mem_rvalid = 1'b0;
    chk("slw_b1_valid", 64'(a_mem_valid), 64'h1);
    chk("slw_b1_addr", 64'(a_mem_addr), 64'h104);
    chk("slw_b1_strb", 64'(a_mem_wstrb), 64'h1);
    a_mem_ready = 1'b1;
    tick();
    a_mem_ready = 1'b0;
    tick(); tick();
    chk("slw_b1_rsp0", 64'(a_rsp_valid), 64'h0);
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h1122_3344;
    tick();
    a_mem_rvalid = 1'b0;
    chk("slw_rsp", 64'(a_rsp_valid), 64'h1);
    chk("slw_rdata", 64'(a_rsp_rdata), 64'h44AA_BBCC);
    tick();

    // strict alignment and illegal funct3
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = 3'b001; b_req_addr = 32'h103;
    tick();
    b_req_valid = 1'b0;
    chk("mis_mvalid", 64'(b_mem_valid), 64'h0);
    chk("mis_rsp", 64'(b_rsp_valid), 64'h1);
    chk("mis_err", 64'(b_rsp_err), 64'h1);
    chk("mis_rdata", 64'(b_rsp_rdata), 64'h0);
    tick();
    chk("mis_done", 64'(b_rsp_valid), 64'h0);
    chk("mis_ready", 64'(b_req_ready), 64'h1);
    b_req_valid = 1'b1; b_req_funct3 = 3'b011; b_req_addr = 32'h100;
    tick();
    b_req_valid = 1'b0;
    chk("ill_mvalid", 64'(b_mem_valid), 64'h0);
    chk("ill_rsp", 64'(b_rsp_valid), 64'h1);
    chk("ill_err", 64'(b_rsp_err), 64'h1);
    tick();
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_funct3 = 3'b100; b_req_addr = 32'h100;
    tick();
    b_req_valid = 1'b0; b_req_we = 1'b0;
    chk("ill_st_err", 64'(b_rsp_err), 64'h1);
    chk("ill_st_mvalid", 64'(b_mem_valid), 64'h0);
    tick();

    // reset while waiting for read data
    a_req_valid = 1'b1; a_req_funct3 = 3'b010; a_req_addr = 32'h200;
    tick();
    a_req_valid = 1'b0; a_mem_ready = 1'b1;
    tick();
    a_mem_ready = 1'b0;
    chk("rmid_wait", 64'(a_req_ready), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_mvalid", 64'(a_mem_valid), 64'h0);
    chk("rmid_maddr", 64'(a_mem_addr), 64'h0);
    chk("rmid_rsp", 64'(a_rsp_valid), 64'h0);
    tick();
    rst_n = 1'b1;
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h1234_5678;
    tick();
    a_mem_rvalid = 1'b0;
    chk("rmid_late_rsp", 64'(a_rsp_valid), 64'h0);
    tick();
    chk("rmid_late_rsp2", 64'(a_rsp_valid), 64'h0);
    a_load("lw_after_rst", 3'b010, 32'h300, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // 64-bit configuration
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_funct3 = 3'b011; c_req_addr = 32'h8;
    tick();
    c_req_valid = 1'b0;
    chk("ld_maddr", 64'(c_mem_addr), 64'h8);
    chk("ld_strb", 64'(c_mem_wstrb), 64'hFF);
    c_mem_ready = 1'b1;
    tick();
    c_mem_ready = 1'b0; c_mem_rvalid = 1'b1; c_mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    c_mem_rvalid = 1'b0;
    chk("ld_rsp", 64'(c_rsp_valid), 64'h1);
    chk("ld_rdata", c_rsp_rdata, 64'h0123_4567_89AB_CDEF);
    tick();
    c_req_valid = 1'b1; c_req_we = 1'b1; c_req_funct3 = 3'b011; c_req_addr = 32'h8;
    c_req_wdata = 64'h1122_3344_5566_7788;
    tick();
    c_req_valid = 1'b0;
    chk("sd_strb", 64'(c_mem_wstrb), 64'hFF);
    chk("sd_wdata", c_mem_wdata, 64'h1122_3344_5566_7788);
    chk("sd_we", 64'(c_mem_we), 64'h1);
    c_mem_ready = 1'b1;
    tick();
    c_mem_ready = 1'b0;
    chk("sd_rsp", 64'(c_rsp_valid), 64'h1);
    tick();
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_funct3 = 3'b010; c_req_addr = 32'hC;
    tick();
    c_req_valid = 1'b0;
    chk("lw64_maddr", 64'(c_mem_addr), 64'h8);
    chk("lw64_strb", 64'(c_mem_wstrb), 64'hF0);
    c_mem_ready = 1'b1;
    tick();
    c_mem_ready = 1'b0; c_mem_rvalid = 1'b1; c_mem_rdata = 64'h8000_0000_0000_0000;
    tick();
    c_mem_rvalid = 1'b0;
    chk("lw64_rdata", c_rsp_rdata, 64'hFFFF_FFFF_8000_0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Parametrised load/store access unit between the core's execute stage and a word-wide data bus.
- Generalises the fixed byte/half/word access scheme to XLEN of 32 or 64, adding LD/LWU/SD when XLEN=64.
- Performs byte-lane steering, write strobes and sign/zero extension of load data.
- Optionally splits misaligned accesses that cross a bus-word boundary into two bus beats; otherwise it flags them as errors.

Parameters:
- XLEN, 32, data/bus width in bits; legal values 32 or 64. NB = XLEN/8 byte lanes.
- ADDR_W, 32, byte-address width.
- ALLOW_MISALIGNED, 1.
  - 1: any access crossing an NB-byte boundary is split into two beats.
  - 0: any access not naturally aligned to its size returns an error.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request; high exactly when FSM is in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V load/store funct3 (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- mem_valid  out  1  bus beat request.
- mem_ready  in  1  bus accepts beat when mem_valid & mem_ready.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  NB-aligned beat address (low log2(NB) bits zero).
- mem_wstrb  out  NB  byte write enables.
- mem_wdata  out  XLEN  lane-steered write data.
- mem_rvalid  in  1  read data valid for the outstanding read beat.
- mem_rdata  in  XLEN  read data.
- rsp_valid  out  1  single-cycle completion pulse.
- rsp_rdata  out  XLEN  extended load result; 0 for stores and errors.
- rsp_err  out  1  misaligned (ALLOW_MISALIGNED=0) or illegal funct3; qualified by rsp_valid.

Behaviour:
- Reset: FSM to IDLE. mem_valid, mem_we, mem_wstrb, mem_wdata, mem_addr, rsp_valid, rsp_rdata, rsp_err all 0. Internal byte buffer cleared.
- Reset mid-operation: the in-flight access is abandoned with no response, and any pending mem_rvalid is ignored.
- Size: B=1, H=2, W=4, D=8 bytes. off = addr mod NB. split = (off + size > NB).
- Illegal funct3: 111, and 011/110 when XLEN=32; for stores, any funct3 above 011.
- Illegal or misaligned-with-ALLOW_MISALIGNED=0 requests:
  - Accepted, no bus traffic.
  - Next cycle: rsp_valid=1, rsp_err=1.
- FSM states: IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, RESP.
  - IDLE: on req_valid, latch the request → B0_REQ, or → RESP with error.
  - B0_REQ: mem_valid=1 held, with stable addr/strobe/data, until mem_ready.
    - Store: → B1_REQ if split, else → RESP.
    - Load: → B0_WAIT.
  - B0_WAIT: on mem_rvalid, capture bytes → B1_REQ if split, else → RESP.
  - B1_REQ / B1_WAIT: same handshake for beat 1 at mem_addr = beat0 addr + NB.
  - RESP: rsp_valid=1 for exactly one cycle → IDLE.
  - req_ready is low in every state except IDLE, so a new request can be accepted in the cycle after RESP at the earliest.
- Bus rules:
  - At most one beat outstanding.
  - Stores are posted: complete on the mem_ready handshake, no mem_rvalid expected.
  - Loads: mem_rvalid arrives at least 1 cycle after the handshake; a mem_rvalid outside a WAIT state is ignored.
- Store steering:
  - Beat 0: wstrb = ((1<<size)-1) << off, truncated to NB; wdata = req_wdata << (8·off).
  - Beat 1: remaining bytes in lanes 0..(off+size-NB-1); wstrb and wdata set accordingly; upper lanes 0.
- Load assembly:
  - Bytes from beat 0 lanes off..NB-1 form the low result bytes.
  - Beat 1 lanes 0.. fill the rest, little-endian.
  - Then extend per funct3: B/H/W sign-extend to XLEN; BU/HU/WU zero-extend; D is unmodified.
- Latency, aligned load with zero-wait bus:
  - Request accepted cycle 0; mem_valid cycle 1 (ready same cycle); mem_rvalid cycle 2; rsp_valid cycle 3.
  - Aligned store: rsp_valid cycle 2.
  - Split access adds 2 cycles (load) or 1 cycle (store).
- mem_ready held low indefinitely: the unit waits; no timeout.

Test Plan:
- XLEN=32, LW 0x100, mem_rdata 0xDEADBEEF → mem_addr 0x100, mem_we 0; rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid in cycle 3 with zero-wait bus.
- LB 0x103, word 0x80FFFFFF → rsp 0xFFFFFF80; LBU same → 0x00000080; LHU 0x102, word 0x80FF1234 → 0x000080FF.
- ALLOW_MISALIGNED=1, SW 0x11223344 @0x102 → beat0 addr 0x100 wstrb 1100 wdata 0x33440000; beat1 addr 0x104 wstrb 0011 wdata 0x00001122; one rsp_valid.
- Split LW @0x101, words 0xAABBCCDD then 0x11223344, mem_rvalid delayed 3 cycles each → rsp 0x44AABBCC.
- ALLOW_MISALIGNED=0, LH @0x103 → no mem_valid ever; rsp_valid=1 with rsp_err=1 the cycle after acceptance. Also, XLEN=32 funct3 011 → same error response.
- Assert rst_n low during B0_WAIT with mem_ready low → all outputs 0 immediately, no rsp_valid; late mem_rvalid ignored; next LW completes normally. XLEN=64 LD @0x8 → single beat, wstrb/data full 8 bytes.
